// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter onto one synchronous data bus, with tie-break by last owner.
// Define DBUS_ARB_BURST_LIMIT_EN to force a handoff after MaxBurst transfers when the other master waits.
module dbus_arbiter #(
    parameter int AddressWidth = 16,
    parameter int DataWidth    = 16,
    parameter int MaxBurst     = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    M0Req,
    input  logic [AddressWidth-1:0] M0Address,
    input  logic [DataWidth-1:0]    M0WriteData,
    input  logic                    M0WriteEnable,
    output logic                    M0Grant,
    output logic [DataWidth-1:0]    M0ReadData,
    output logic                    M0ReadValid,
    input  logic                    M1Req,
    input  logic [AddressWidth-1:0] M1Address,
    input  logic [DataWidth-1:0]    M1WriteData,
    input  logic                    M1WriteEnable,
    output logic                    M1Grant,
    output logic [DataWidth-1:0]    M1ReadData,
    output logic                    M1ReadValid,
    output logic [AddressWidth-1:0] SAddress,
    output logic [DataWidth-1:0]    SWriteData,
    output logic                    SWriteEnable,
    input  logic [DataWidth-1:0]    SReadData
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    if (MaxBurst < 2 || MaxBurst > 255) begin : g_bad_burst
        $error("MaxBurst must be in 2..255");
    end

    logic [1:0] state_q, state_d;
    logic       last_q, last_d;
    logic       rv0_q, rv1_q;
    logic       own0, own1, limit;

    assign own0 = state_q == OWN0;
    assign own1 = state_q == OWN1;
    assign M0Grant = own0;
    assign M1Grant = own1;

    assign SAddress     = own0 ? M0Address : own1 ? M1Address : '0;
    assign SWriteData   = own0 ? M0WriteData : own1 ? M1WriteData : '0;
    assign SWriteEnable = (own0 & M0Req & M0WriteEnable) | (own1 & M1Req & M1WriteEnable);

    assign M0ReadValid = rv0_q;
    assign M1ReadValid = rv1_q;
    assign M0ReadData  = rv0_q ? SReadData : '0;
    assign M1ReadData  = rv1_q ? SReadData : '0;

    // Unreachable encoding 3 falls into the IDLE decision so it recovers in one cycle.
    always_comb begin
        state_d = own0 ? (!M0Req ? (M1Req ? OWN1 : IDLE) : (M1Req && limit) ? OWN1 : OWN0) :
                  own1 ? (!M1Req ? (M0Req ? OWN0 : IDLE) : (M0Req && limit) ? OWN0 : OWN1) :
                  (M0Req && (!M1Req || last_q)) ? OWN0 : M1Req ? OWN1 : IDLE;
        last_d  = (state_d == OWN0) ? 1'b0 : (state_d == OWN1) ? 1'b1 : last_q;
    end

`ifdef DBUS_ARB_BURST_LIMIT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       xfer;

    assign xfer  = (own0 & M0Req) | (own1 & M1Req);
    assign limit = cnt_q == 8'(MaxBurst - 1);

    always_comb begin
        cnt_d = (state_d != state_q) ? 8'd0 : (xfer && !limit) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge Clock) begin
        cnt_q <= Reset ? 8'd0 : cnt_d;
    end
`else
    assign limit = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            rv0_q   <= own0 & M0Req & ~M0WriteEnable;
            rv1_q   <= own1 & M1Req & ~M1WriteEnable;
        end
    end
endmodule

// File: doc/dbus_arbiter.md
DBUS_ARBITER -- requirements
Module: dbus_arbiter

Interface
REQ-001 SHALL have parameter AddressWidth, default 16, width of all address ports.
REQ-002 SHALL have parameter DataWidth, default 16, width of all data ports.
REQ-003 SHALL have parameter MaxBurst, default 8, range 2-255; maximum consecutive transfers one master may make while the other requests.
REQ-004 SHALL have port Clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports M0Req / M1Req  input  1  master n requests one transfer in this cycle.
REQ-007 SHALL have ports M0Address / M1Address  input  AddressWidth  transfer address.
REQ-008 SHALL have ports M0WriteData / M1WriteData  input  DataWidth  write data.
REQ-009 SHALL have ports M0WriteEnable / M1WriteEnable  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports M0Grant / M1Grant  output  1  registered; master n owns the bus this cycle.
REQ-011 SHALL have ports M0ReadData / M1ReadData  output  DataWidth  read result.
REQ-012 SHALL have ports M0ReadValid / M1ReadValid  output  1  registered; ReadData is valid this cycle.
REQ-013 SHALL have port SAddress  output  AddressWidth  address to the shared data bus.
REQ-014 SHALL have port SWriteData  output  DataWidth  write data to the shared bus.
REQ-015 SHALL have port SWriteEnable  output  1  write strobe to the shared bus.
REQ-016 SHALL have port SReadData  input  DataWidth  read data from the shared bus, returned one cycle after the address (synchronous memories).

Function
REQ-017 SHALL implement states IDLE, OWN0, OWN1; M0Grant = (state==OWN0), M1Grant = (state==OWN1); at most one grant is high in any cycle.
REQ-018 SHALL, in each cycle, treat a transfer as occurring iff the granted master has Req high.
REQ-019 SHALL drive SAddress/SWriteData from the granted master, and drive SWriteEnable = granted Req & granted WriteEnable; in IDLE, SAddress=0, SWriteData=0, SWriteEnable=0.
REQ-020 SHALL, from IDLE: with only MnReq high, go to OWNn; with both high, go to the master other than LastOwner; with neither, stay in IDLE.
REQ-021 SHALL, from OWNn with MnReq low: go to the other OWN state if the other master requests, else to IDLE (no idle gap on handoff).
REQ-022 SHALL hold a burst counter, cleared on every state entry and incremented on each transfer, saturating at MaxBurst-1.
REQ-023 SHALL, from OWNn with MnReq high, the other master requesting, and the counter at MaxBurst-1, move to the other OWN state at the next edge.
REQ-024 SHALL, from OWNn with MnReq high and the other master idle, stay in OWNn indefinitely.
REQ-025 SHALL update LastOwner to n on every entry to OWNn.
REQ-026 SHALL assert MnReadValid exactly one cycle after a read transfer by master n, with MnReadData = SReadData in that cycle; otherwise MnReadData=0 and MnReadValid=0.
REQ-027 SHALL deliver a read issued in the final cycle before a handoff to the original master, even though the other master owns the bus in the delivery cycle.
REQ-028 SHALL not alter any write for a master that requests without a grant; that master holds its Req and signals until granted.

Reset
REQ-029 SHALL, on a rising edge with Reset high, enter IDLE, set LastOwner=1 (M0 wins the first tie), clear the counter, and clear both ReadValids. Both Grants are 0 and all S outputs are 0 in the following cycle.
REQ-030 SHALL, when Reset is asserted mid-burst, discard the pending read valid and not repeat any transfer after reset.

Configuration
REQ-031 SHALL use macro DBUS_ARB_BURST_LIMIT_EN. When defined, REQ-022 and REQ-023 apply. When undefined, there is no counter and the owner keeps the bus until its Req drops (REQ-021 only).

Verification
REQ-032 Reset, then M0Req=1 only -> M0Grant=1 on the next cycle; SWriteEnable follows M0WriteEnable; M1Grant stays 0.
REQ-033 Both Req high from IDLE after reset -> OWN0 first; M0 holds Req with MaxBurst=8 -> exactly 8 M0 transfers, then M1Grant=1 at the next edge with no gap.
REQ-034 M0 reads 0x0040 in its last owned cycle, memory returns 0x1234 -> M0ReadValid=1, M0ReadData=0x1234 while M1Grant=1; M1ReadValid=0.
REQ-035 M1Req alone for 20 cycles -> M1Grant held all 20 cycles; no IDLE insertion; counter saturates without switching.
REQ-036 Reset asserted during an M1 burst with a read outstanding -> next cycle both Grants=0, both ReadValids=0, SWriteEnable=0.
REQ-037 DBUS_ARB_BURST_LIMIT_EN undefined, both Req held 30 cycles -> M0 keeps the grant all 30 cycles.
